lcd_byte_writer: RTL and testbench

- Upstream feeder for the 16x2 HD44780 character LCD, sitting directly in front of the LCD pins: rs, en, data[7:0].
- Accepts command and data bytes from any producer, such as a text formatter or init sequencer, over a valid/ready handshake.
- Buffers the bytes in a small FIFO and plays each one out with correct setup, enable pulse width and post-write busy delay.
- Replaces per-character hard-coded state sequences with one reusable byte engine.

---
 rtl/lcd_byte_writer.sv | 140 ++++++++++++++
 tb/tb_lcd_byte_writer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_byte_writer.sv
// Byte engine for an HD44780 character LCD: buffers {rs, data} bytes in a small FIFO
// and plays each one out with address setup, a timed enable pulse and a post-write wait.
module lcd_byte_writer #(
  parameter int EN_HIGH    = 12,
  parameter int SHORT_WAIT = 2000,
  parameter int LONG_WAIT  = 82000,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 20
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_rs,
  input  logic [7:0]                    in_data,
  output logic                          en,
  output logic                          rs,
  output logic [7:0]                    data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [PTR_W:0]   FULL_CNT   = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   ONE_CNT    = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] ONE_PTR    = PTR_W'(1);
  localparam logic [CNT_W-1:0] ONE_DLY    = CNT_W'(1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_HIGH - 1);
  localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(SHORT_WAIT - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_WAIT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             long_q, long_d;
  logic             en_q, en_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [8:0]       mem_q [FIFO_DEPTH];
  logic             push, pop;

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  always_comb begin
    push     = in_valid && (count_q != FULL_CNT);
    pop      = (state_q == IDLE) && (count_q != '0);
    wr_ptr_d = push ? wr_ptr_q + ONE_PTR : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + ONE_PTR : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + ONE_CNT;
    end else if (pop && !push) begin
      count_d = count_q - ONE_CNT;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    long_d  = long_q;
    en_d    = 1'b0;
    rs_d    = rs_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          {rs_d, data_d} = mem_q[rd_ptr_q];
          cnt_d          = '0;
          state_d        = SETUP;
        end
      end
      SETUP: begin
        en_d    = 1'b1;
        state_d = PULSE;
      end
      PULSE: begin
        if (cnt_q == EN_LAST) begin
          cnt_d   = '0;
          // Clear display and return home need the long settle time.
          long_d  = !rs_q && (data_q[7:2] == 6'd0) && (data_q != 8'd0);
          state_d = WAIT;
        end else begin
          en_d  = 1'b1;
          cnt_d = cnt_q + ONE_DLY;
        end
      end
      WAIT: begin
        if (cnt_q == (long_q ? LONG_LAST : SHORT_LAST)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ONE_DLY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_rs, in_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      long_q   <= 1'b0;
      en_q     <= 1'b0;
      rs_q     <= 1'b0;
      data_q   <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      long_q   <= long_d;
      en_q     <= en_d;
      rs_q     <= rs_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign in_ready   = (count_q != FULL_CNT);
  assign en         = en_q;
  assign rs         = rs_q;
  assign data       = data_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign fifo_count = count_q;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Self-checking bench for lcd_byte_writer: a timeline reference model predicts every
// output each cycle; table vectors and directed sequences cover wait lengths, backpressure and reset.
module tb_lcd_byte_writer;

  localparam int EN_HIGH    = 3;
  localparam int SHORT_WAIT = 10;
  localparam int LONG_WAIT  = 40;
  localparam int DEPTH      = 4;
  localparam int CNT_W      = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_rs = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       en;
  logic       rs;
  logic [7:0] data;
  logic       busy;
  logic [2:0] fifo_count;

  lcd_byte_writer #(
    .EN_HIGH(EN_HIGH), .SHORT_WAIT(SHORT_WAIT), .LONG_WAIT(LONG_WAIT),
    .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_data(in_data), .en(en), .rs(rs), .data(data),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: pending bytes plus the edge numbers of the current write.
  logic [8:0] mq[$];
  int         m_rise = -1;
  int         m_fall = -1;
  int         m_free = 0;
  logic       m_rs   = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit         acc    = 1'b0;

  logic       prev_en  = 1'b0;
  bit         saw_full = 1'b0;
  int         rise_log[$];
  int         fall_log[$];
  logic [8:0] obs_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (edge %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rise = -1;
    m_fall = -1;
    m_free = 0;
    m_rs   = 1'b0;
    m_data = 8'h00;
    acc    = 1'b0;
  endtask

  // Timeline rule: a byte leaves the FIFO one edge after it is present and the engine
  // is free; en is high for EN_HIGH edges after that, then the wait, then one more edge.
  task automatic model_step();
    int         cnt_before;
    int         w;
    logic [8:0] item;
    cnt_before = mq.size();
    acc = in_valid && (cnt_before != DEPTH);
    if (cnt_before > 0 && cyc >= m_free) begin
      item   = mq.pop_front();
      m_rs   = item[8];
      m_data = item[7:0];
      w      = (!m_rs && m_data >= 8'd1 && m_data <= 8'd3) ? LONG_WAIT : SHORT_WAIT;
      m_rise = cyc + 1;
      m_fall = cyc + 1 + EN_HIGH;
      m_free = cyc + 2 + EN_HIGH + w;
    end
    if (acc) mq.push_back({in_rs, in_data});
  endtask

  task automatic checkOutput();
    logic exp_en;
    logic exp_busy;
    int   exp_cnt;
    exp_en   = (cyc >= m_rise) && (cyc < m_fall);
    exp_busy = (cyc < m_free - 1) || (mq.size() != 0);
    exp_cnt  = mq.size();
    check("en", 32'(en), 32'(exp_en));
    check("rs_data", 32'({rs, data}), 32'({m_rs, m_data}));
    check("busy", 32'(busy), 32'(exp_busy));
    check("fifo_count", 32'(fifo_count), 32'(exp_cnt));
    check("in_ready", 32'(in_ready), 32'(exp_cnt != DEPTH));
    if (en && !prev_en) begin
      rise_log.push_back(cyc);
      obs_log.push_back({rs, data});
    end
    if (!en && prev_en) fall_log.push_back(cyc);
    if (fifo_count == 3'd4 && !in_ready) saw_full = 1'b1;
    prev_en = en;
  endtask

  task automatic applyStimulus(input logic v, input logic r, input logic [7:0] d);
    in_valid = v;
    in_rs    = r;
    in_data  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else     model_step();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic pushByte(input logic r, input logic [7:0] d, output int edge_n);
    int k;
    k = 0;
    applyStimulus(1'b1, r, d);
    do begin
      tick();
      k++;
    end while (!acc && k < 1000);
    if (!acc) check("push_timeout", 32'(0), 32'(1));
    edge_n = cyc;
    applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic waitIdle(input int limit);
    int k;
    k = 0;
    while (busy && k < limit) begin
      tick();
      k++;
    end
    check("idle_timeout", 32'(busy), 32'(0));
  endtask

  task automatic clearLogs();
    rise_log.delete();
    fall_log.delete();
    obs_log.delete();
    saw_full = 1'b0;
  endtask

  typedef struct {
    logic       r;
    logic [7:0] d;
    int         exp_wait;
  } vec_t;

  initial begin
    vec_t tbl[9];
    int   e;
    int   e2;
    int   k;

    tbl[0] = '{1'b1, 8'h4D, SHORT_WAIT};
    tbl[1] = '{1'b0, 8'h01, LONG_WAIT};
    tbl[2] = '{1'b0, 8'h02, LONG_WAIT};
    tbl[3] = '{1'b0, 8'h03, LONG_WAIT};
    tbl[4] = '{1'b0, 8'h00, SHORT_WAIT};
    tbl[5] = '{1'b0, 8'h04, SHORT_WAIT};
    tbl[6] = '{1'b1, 8'h01, SHORT_WAIT};
    tbl[7] = '{1'b0, 8'h0C, SHORT_WAIT};
    tbl[8] = '{1'b0, 8'h80, SHORT_WAIT};

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Single writes from idle: latency, pulse width and wait length per byte class
    for (int i = 0; i < 9; i++) begin
      clearLogs();
      pushByte(tbl[i].r, tbl[i].d, e);
      waitIdle(200);
      check("rise_count", 32'(rise_log.size()), 32'(1));
      check("fall_count", 32'(fall_log.size()), 32'(1));
      if (rise_log.size() == 1 && fall_log.size() == 1) begin
        check("en_latency", 32'(rise_log[0] - e), 32'(2));
        check("en_width", 32'(fall_log[0] - rise_log[0]), 32'(EN_HIGH));
        check("wait_len", 32'(cyc - fall_log[0]), 32'(tbl[i].exp_wait));
        check("byte_out", 32'(obs_log[0]), 32'({tbl[i].r, tbl[i].d}));
      end
      repeat (2) tick();
    end

    // Clear followed by an ordinary command
    clearLogs();
    pushByte(1'b0, 8'h01, e);
    pushByte(1'b0, 8'h0C, e2);
    waitIdle(300);
    check("clr_rises", 32'(rise_log.size()), 32'(2));
    if (rise_log.size() == 2 && fall_log.size() == 2) begin
      check("clr_period", 32'(rise_log[1] - rise_log[0]), 32'(EN_HIGH + LONG_WAIT + 2));
      check("cmd_wait", 32'(cyc - fall_log[1]), 32'(SHORT_WAIT));
    end

    // Backpressure: six bytes with in_valid held high
    clearLogs();
    for (int i = 0; i < 6; i++) pushByte(1'b1, 8'h30 + 8'(i), e);
    waitIdle(500);
    check("saw_full", 32'(saw_full), 32'(1));
    check("bp_rises", 32'(rise_log.size()), 32'(6));
    if (rise_log.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check("bp_order", 32'(obs_log[i]), 32'({1'b1, 8'h30 + 8'(i)}));
        if (i > 0) check("bp_period", 32'(rise_log[i] - rise_log[i-1]), 32'(EN_HIGH + SHORT_WAIT + 2));
      end
    end

    // Wrap-around with random gaps
    clearLogs();
    for (int i = 0; i < 10; i++) begin
      k = $urandom_range(0, 20);
      repeat (k) tick();
      pushByte(1'b1, 8'h41 + 8'(i), e);
    end
    waitIdle(1000);
    check("wrap_rises", 32'(obs_log.size()), 32'(10));
    if (obs_log.size() == 10) begin
      for (int i = 0; i < 10; i++) check("wrap_order", 32'(obs_log[i]), 32'({1'b1, 8'h41 + 8'(i)}));
    end
    check("wrap_count", 32'(fifo_count), 32'(0));

    // Random traffic against the model
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      k = $urandom_range(0, 6);
      repeat (k) tick();
      pushByte(1'($urandom), d, e);
    end
    waitIdle(2000);

    // Asynchronous reset during PULSE with two bytes queued
    clearLogs();
    pushByte(1'b1, 8'h50, e);
    pushByte(1'b1, 8'h51, e);
    pushByte(1'b1, 8'h52, e);
    k = 0;
    while (!en && k < 50) begin
      tick();
      k++;
    end
    check("pulse_reached", 32'(en), 32'(1));
    check("queued", 32'(fifo_count), 32'(2));
    #2 rst = 1'b1;
    #1;
    check("rst_en", 32'(en), 32'(0));
    check("rst_rs", 32'(rs), 32'(0));
    check("rst_data", 32'(data), 32'(0));
    check("rst_count", 32'(fifo_count), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    model_reset();
    prev_en = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    clearLogs();
    pushByte(1'b1, 8'h48, e);
    waitIdle(200);
    check("post_rst_rises", 32'(rise_log.size()), 32'(1));
    if (rise_log.size() == 1) begin
      check("post_rst_latency", 32'(rise_log[0] - e), 32'(2));
      check("post_rst_byte", 32'(obs_log[0]), 32'({1'b1, 8'h48}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
